// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button pins in, debounced levels, edge pulses and long-press flags out.
interface button_debouncer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_db;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;
  logic [WIDTH-1:0] long_press;
  modport master (
    input  btn_raw,
    output btn_db, press_pulse, release_pulse, long_press
  );
  modport slave (
    output btn_raw,
    input  btn_db, press_pulse, release_pulse, long_press
  );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel synchroniser and debounce FSM with registered press/release pulses.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to build the long-press hold counters; otherwise long_press is 0.
module button_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int LONG_CYCLES     = 50000000
) (
  input logic               clk,
  input logic               reset_n,
  button_debouncer_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic REL = (ACTIVE_LOW != 0);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  logic [WIDTH-1:0] sync1_q, sync2_q, lvl;
  logic [WIDTH-1:0] db_v, pp_v, rp_v, long_v;
  // Sync chain resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {WIDTH{REL}};
      sync2_q <= {WIDTH{REL}};
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end
  assign lvl = REL ? ~sync2_q : sync2_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d, pp_q, pp_d, rp_q, rp_d;
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      db_d    = db_q;
      pp_d    = 1'b0;
      rp_d    = 1'b0;
      case (state_q)
        IDLE:       if (lvl[i]) state_d = PRESS_WAIT;
        PRESS_WAIT:
          if (!lvl[i]) state_d = IDLE;
          else if (cnt_q == LAST) begin
            state_d = PRESSED;
            db_d    = 1'b1;
            pp_d    = 1'b1;
          end else cnt_d = cnt_q + CW'(1);
        PRESSED:    if (!lvl[i]) state_d = RELEASE_WAIT;
        RELEASE_WAIT:
          if (lvl[i]) state_d = PRESSED;
          else if (cnt_q == LAST) begin
            state_d = IDLE;
            db_d    = 1'b0;
            rp_d    = 1'b1;
          end else cnt_d = cnt_q + CW'(1);
        default:    state_d = IDLE;
      endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        pp_q    <= 1'b0;
        rp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        pp_q    <= pp_d;
        rp_q    <= rp_d;
      end
    end
    assign db_v[i] = db_q;
    assign pp_v[i] = pp_q;
    assign rp_v[i] = rp_q;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] LMAX = HW'(LONG_CYCLES);
    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;
    // Hold time restarts only on a debounced rise; a rejected release glitch keeps counting.
    always_comb begin
      hold_d = pp_d ? '0 : (db_q && hold_q != LMAX) ? hold_q + HW'(1) : hold_q;
      long_d = db_d && (hold_d == LMAX);
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end
    assign long_v[i] = long_q;
`else
    assign long_v[i] = 1'b0;
`endif
  end
  assign bus.btn_db        = db_v;
  assign bus.press_pulse   = pp_v;
  assign bus.release_pulse = rp_v;
  assign bus.long_press    = long_v;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed and random stimulus checked cycle by cycle against a stability-window model.
module tb_button_debouncer;
  localparam int W  = 2;
  localparam int DC = 4;
  localparam int LC = 20;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  logic clk, reset_n;
  int tests, fails;
  button_debouncer_if #(.WIDTH(W)) bus ();
  button_debouncer #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: a channel flips once its pressed level has disagreed with the output for DC+1 FSM samples.
  logic [1:0] samp[$];
  logic [1:0] lq[$];
  logic [1:0] mdb, mpp, mrp, mlong;
  int held[W];
  function automatic void model_reset();
    samp = '{2'b11, 2'b11};
    lq.delete();
    for (int k = 0; k <= DC; k++) lq.push_back(2'b00);
    mdb = '0; mpp = '0; mrp = '0; mlong = '0;
    for (int c = 0; c < W; c++) held[c] = 0;
  endfunction
  function automatic void model_edge(input logic [1:0] raw);
    logic [1:0] lvl;
    bit stable;
    samp.push_back(raw);
    lvl = ~samp.pop_front();
    lq.push_back(lvl);
    void'(lq.pop_front());
    for (int c = 0; c < W; c++) begin
      stable = 1'b1;
      foreach (lq[k]) if (lq[k][c] == mdb[c]) stable = 1'b0;
      mpp[c] = stable && !mdb[c];
      mrp[c] = stable && mdb[c];
      if (stable) mdb[c] = ~mdb[c];
      if (mpp[c]) held[c] = 0;
      else if (mdb[c]) held[c]++;
      mlong[c] = LONG_EN && mdb[c] && held[c] >= LC;
    end
  endfunction
  int cyc, pp_n[W], rp_n[W], rise_at[W], fall_at[W], long_at[W], long_n[W];
  task automatic mark();
    cyc = 0;
    for (int c = 0; c < W; c++) begin
      pp_n[c] = 0; rp_n[c] = 0; rise_at[c] = -1; fall_at[c] = -1; long_at[c] = -1; long_n[c] = 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge(bus.btn_raw);
    #1;
    cyc++;
    check("btn_db", 32'(bus.btn_db), 32'(mdb));
    check("press_pulse", 32'(bus.press_pulse), 32'(mpp));
    check("release_pulse", 32'(bus.release_pulse), 32'(mrp));
    check("long_press", 32'(bus.long_press), 32'(mlong));
    for (int c = 0; c < W; c++) begin
      if (bus.press_pulse[c]) begin pp_n[c]++; rise_at[c] = cyc; end
      if (bus.release_pulse[c]) begin rp_n[c]++; fall_at[c] = cyc; end
      if (bus.long_press[c] && long_at[c] < 0) long_at[c] = cyc;
      if (bus.long_press[c]) long_n[c]++;
    end
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_db", 32'(bus.btn_db), 0);
    check("rst_pp", 32'(bus.press_pulse), 0);
    check("rst_rp", 32'(bus.release_pulse), 0);
    check("rst_long", 32'(bus.long_press), 0);
    model_reset();
    #3 reset_n = 1'b1;
  endtask
  task automatic drive_seq(input int ch, input logic [15:0] pat, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      bus.btn_raw[ch] = pat[k];
      tick();
    end
  endtask
  initial begin
    int left[W];
    tests = 0; fails = 0;
    bus.btn_raw = 2'b11;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mark();
    ticks(15);
    check("idle_pp", 32'(pp_n[0] + pp_n[1] + rp_n[0] + rp_n[1]), 0);
    // Single press of bit 0, driven just after edge 0.
    bus.btn_raw[0] = 1'b0;
    mark();
    ticks(12);
    check("press_lat", 32'(rise_at[0]), 7);
    check("press_cnt", 32'(pp_n[0]), 1);
    check("press_b1", 32'(pp_n[1]), 0);
    bus.btn_raw[0] = 1'b1;
    mark();
    ticks(12);
    check("rel_lat", 32'(fall_at[0]), 7);
    // Bouncy press: toggle every 2 cycles, then settle pressed.
    mark();
    drive_seq(0, 16'b0011_0011, 8);
    check("bounce_none", 32'(pp_n[0]), 0);
    bus.btn_raw[0] = 1'b0;
    mark();
    ticks(12);
    check("bounce_lat", 32'(rise_at[0]), 7);
    check("bounce_cnt", 32'(pp_n[0]), 1);
    // Release with a 3-cycle low glitch inside it.
    mark();
    drive_seq(0, 16'b11000, 5);
    check("glitch_none", 32'(rp_n[0]), 0);
    bus.btn_raw[0] = 1'b1;
    mark();
    ticks(12);
    check("glitch_lat", 32'(fall_at[0]), 7);
    check("glitch_cnt", 32'(rp_n[0]), 1);
    // Both channels together, then reset in the middle of a new press.
    bus.btn_raw = 2'b00;
    mark();
    ticks(10);
    check("both_same", 32'(rise_at[1]), 32'(rise_at[0]));
    check("both_lat", 32'(rise_at[1]), 7);
    bus.btn_raw = 2'b11;
    ticks(10);
    bus.btn_raw = 2'b00;
    mark();
    ticks(4);
    do_reset();
    ticks(3);
    check("midwait_none", 32'(pp_n[0] + pp_n[1]), 0);
    ticks(9);
    check("redebounce", 32'(pp_n[0] + pp_n[1]), 2);
    bus.btn_raw = 2'b11;
    ticks(12);
    // Long hold on bit 1.
    bus.btn_raw[1] = 1'b0;
    mark();
    ticks(35);
    bus.btn_raw[1] = 1'b1;
    ticks(12);
    if (LONG_EN) begin
      check("long_delay", 32'(long_at[1] - rise_at[1]), LC);
      check("long_len", 32'(long_n[1]), 32'(fall_at[1] - long_at[1]));
    end else check("long_off", 32'(long_n[1]), 0);
    // Random independent activity on both channels.
    for (int c = 0; c < W; c++) left[c] = 0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < W; c++) begin
        if (left[c] == 0) begin
          bus.btn_raw[c] = 1'($urandom_range(0, 1));
          left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 7);
        end
        left[c]--;
      end
      if (k == 300) do_reset();
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
